pio_period_meter: RTL and testbench

//  Measures the period of an external PIO pin and reports it as a 16.8 fixed-point clock divisor.

---
 rtl/pio_pkg.sv | 13 +
 rtl/pio_period_meter_if.sv | 23 ++
 rtl/pio_sync_edge.sv | 27 ++
 rtl/pio_period_meter.sv | 138 +++++++++++++
 tb/tb_pio_period_meter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared PIO types and widths: divisor format and the period-meter FSM states.
package pio_pkg;

  localparam int PIO_DIV_W      = 24;
  localparam int PIO_DIV_FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } pio_pm_state_t;

endpackage

// File: rtl/pio_period_meter_if.sv
// Pin/control/result bundle of the PIO period meter; slave = meter, master = its user.
interface pio_period_meter_if;
  import pio_pkg::*;

  logic                 enable;
  logic                 sig;
  logic [PIO_DIV_W-1:0] div;
  logic                 div_valid;
  logic                 locked;
  logic                 timeout;
  logic                 glitch;

  modport master (
    output enable, sig,
    input  div, div_valid, locked, timeout, glitch
  );

  modport slave (
    input  enable, sig,
    output div, div_valid, locked, timeout, glitch
  );

endinterface

// File: rtl/pio_sync_edge.sv
// Synchronizer for an asynchronous pin plus a registered one-cycle rising-edge pulse.
module pio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // rise is registered, so a pin edge shows up SYNC_STAGES+1 cycles later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      prev <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/pio_period_meter.sv
// Measures a PIO pin period averaged over 2^AVG_LOG2 intervals, reported as a 16.8 divisor.
// Optional deviation check enabled by defining PIO_PERIOD_METER_TOLERANCE_EN.
module pio_period_meter
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 3
) (
  input logic               clk,
  input logic               reset_n,
  pio_period_meter_if.slave bus
);

  localparam int ACC_W  = 16 + AVG_LOG2;
  localparam int ECNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'((1 << AVG_LOG2) - 1);

  // Window sum scaled to 16.8 and divided by the interval count; exact, then truncated.
  function automatic logic [PIO_DIV_W-1:0] window_div(input logic [ACC_W-1:0] a);
    logic [ACC_W+PIO_DIV_FRAC_W-1:0] w;
    w = {a, {PIO_DIV_FRAC_W{1'b0}}} >> AVG_LOG2;
    return w[PIO_DIV_W-1:0];
  endfunction

`ifdef PIO_PERIOD_METER_TOLERANCE_EN
  function automatic logic out_of_tol(input logic [PIO_DIV_W-1:0] nw,
                                      input logic [PIO_DIV_W-1:0] old);
    logic [PIO_DIV_W-1:0] d;
    d = (nw > old) ? (nw - old) : (old - nw);
    return d > (old >> 4);
  endfunction
`endif

  logic                 rise;
  pio_pm_state_t        state;
  logic [ACC_W-1:0]     acc;
  logic [ECNT_W-1:0]    ecnt;
  logic [PIO_DIV_W-1:0] div_q;
  logic [PIO_DIV_W-1:0] div_next;
  logic                 div_valid_q;
  logic                 locked_q;
  logic                 timeout_q;
  logic                 glitch_q;
`ifdef PIO_PERIOD_METER_TOLERANCE_EN
  logic                 ref_ok;
`endif

  pio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (bus.sig),
    .rise    (rise)
  );

  assign div_next = window_div(acc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc         <= '0;
      ecnt        <= '0;
      div_q       <= '0;
      div_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      glitch_q    <= 1'b0;
`ifdef PIO_PERIOD_METER_TOLERANCE_EN
      ref_ok      <= 1'b0;
`endif
    end else begin
      div_valid_q <= 1'b0;
      glitch_q    <= 1'b0;
      if (!bus.enable) begin
        state     <= IDLE;
        acc       <= '0;
        ecnt      <= '0;
        locked_q  <= 1'b0;
        timeout_q <= 1'b0;
`ifdef PIO_PERIOD_METER_TOLERANCE_EN
        ref_ok    <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              acc   <= ACC_W'(1);
              ecnt  <= '0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            // A rise always takes priority over the overflow check
            if (rise && ecnt == ECNT_LAST) begin
              div_q       <= div_next;
              div_valid_q <= 1'b1;
              acc         <= ACC_W'(1);
              ecnt        <= '0;
`ifdef PIO_PERIOD_METER_TOLERANCE_EN
              if (ref_ok && out_of_tol(div_next, div_q)) glitch_q <= 1'b1;
              else                                       locked_q <= 1'b1;
              ref_ok      <= 1'b1;
`else
              locked_q    <= 1'b1;
`endif
            end else if (rise) begin
              ecnt <= ecnt + 1'b1;
              acc  <= acc + 1'b1;
            end else if (&acc) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              state     <= ARM;
`ifdef PIO_PERIOD_METER_TOLERANCE_EN
              ref_ok    <= 1'b0;
`endif
            end else begin
              acc <= acc + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.div       = div_q;
  assign bus.div_valid = div_valid_q;
  assign bus.locked    = locked_q;
  assign bus.timeout   = timeout_q;
`ifdef PIO_PERIOD_METER_TOLERANCE_EN
  assign bus.glitch    = glitch_q;
`else
  assign bus.glitch    = 1'b0;
  logic unused_glitch;
  assign unused_glitch = glitch_q;
`endif

endmodule

// File: tb/tb_pio_period_meter.sv
// Directed bench for pio_period_meter: an AVG_LOG2=3 instance (table vectors, enable drop,
// mid-window reset) and an AVG_LOG2=0 instance (timeout, deviation flag).
module tb_pio_period_meter;
  import pio_pkg::*;

`ifdef PIO_PERIOD_METER_TOLERANCE_EN
  localparam logic TOL = 1'b1;
`else
  localparam logic TOL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pio_period_meter_if if3 ();
  pio_period_meter_if if0 ();

  pio_period_meter #(.SYNC_STAGES(2), .AVG_LOG2(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3));
  pio_period_meter #(.SYNC_STAGES(2), .AVG_LOG2(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));

  int nvec = 0;
  int nmis = 0;

  int pa3 = 10, pb3 = 10;
  bit run3 = 1'b0, idle3 = 1'b1;
  int pa0 = 10, pb0 = 10;
  bit run0 = 1'b0, idle0 = 1'b1;

  typedef struct {
    int          pa;
    int          pb;
    logic [23:0] exp_div;
    int          exp_gap;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Alternating pa3/pb3 periods while run3 is set
  initial begin : gen3
    int cur;
    bit alt;
    alt = 1'b0;
    if3.sig = 1'b0;
    forever begin
      if (run3) begin
        idle3 = 1'b0;
        cur = alt ? pb3 : pa3;
        alt = ~alt;
        if3.sig = 1'b1; repeat (cur / 2) @(negedge clk);
        if3.sig = 1'b0; repeat (cur - cur / 2) @(negedge clk);
      end else begin
        idle3 = 1'b1; alt = 1'b0; if3.sig = 1'b0;
        @(negedge clk);
      end
    end
  end

  // First period pa0, then pb0 for the rest of the run
  initial begin : gen0
    int cur;
    bit first;
    first = 1'b1;
    if0.sig = 1'b0;
    forever begin
      if (run0) begin
        idle0 = 1'b0;
        cur = first ? pa0 : pb0;
        first = 1'b0;
        if0.sig = 1'b1; repeat (cur / 2) @(negedge clk);
        if0.sig = 1'b0; repeat (cur - cur / 2) @(negedge clk);
      end else begin
        idle0 = 1'b1; first = 1'b1; if0.sig = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic wait_valid(input bit which, input int limit, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (which ? if0.div_valid : if3.div_valid) ok = 1'b1;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[7];
    bit   ok;
    int   n;
    bit   saw_valid;

    vt[0] = '{10,  10,  24'h000A00, 80};
    vt[1] = '{10,  11,  24'h000A80, 84};
    vt[2] = '{7,   7,   24'h000700, 56};
    vt[3] = '{16,  17,  24'h001080, 132};
    vt[4] = '{3,   3,   24'h000300, 24};
    vt[5] = '{200, 201, 24'h00C880, 1604};
    vt[6] = '{10,  10,  24'h000A00, 80};

    reset_n = 1'b0;
    if3.enable = 1'b0;
    if0.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_div",       if3.div,       24'h0);
    check("rst_div_valid", if3.div_valid, 1'b0);
    check("rst_locked",    if3.locked,    1'b0);
    check("rst_timeout",   if3.timeout,   1'b0);
    check("rst_glitch",    if3.glitch,    1'b0);
    check("rst_div0",      if0.div,       24'h0);
    check("rst_fsm",       u_dut3.state,  IDLE);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table: each vector restarts the meter and checks two consecutive windows
    for (int i = 0; i < 7; i++) begin
      if3.enable = 1'b0;
      run3 = 1'b0;
      @(negedge clk);
      n = 0;
      while (!idle3 && n < 500) begin @(negedge clk); n++; end
      check("gen_idle", idle3, 1'b1);
      check("idle_locked", if3.locked, 1'b0);
      pa3 = vt[i].pa;
      pb3 = vt[i].pb;
      if3.enable = 1'b1;
      run3 = 1'b1;
      wait_valid(1'b0, 2 * vt[i].exp_gap + 100, ok, n);
      check("first_valid_seen", ok, 1'b1);
      check("first_div", if3.div, vt[i].exp_div);
      check("first_locked", if3.locked, 1'b1);
      check("first_timeout", if3.timeout, 1'b0);
      wait_valid(1'b0, vt[i].exp_gap + 20, ok, n);
      check("second_valid_seen", ok, 1'b1);
      check("window_gap", n, vt[i].exp_gap);
      check("second_div", if3.div, vt[i].exp_div);
      @(negedge clk);
      check("valid_one_cycle", if3.div_valid, 1'b0);
    end

    // Enable dropped for one clock while locked
    if3.enable = 1'b0;
    @(negedge clk);
    if3.enable = 1'b1;
    check("drop_locked", if3.locked, 1'b0);
    check("drop_timeout", if3.timeout, 1'b0);
    check("drop_div_held", if3.div, 24'h000A00);
    @(negedge clk);
    check("reen_locked", if3.locked, 1'b0);
    wait_valid(1'b0, 300, ok, n);
    check("relock_seen", ok, 1'b1);
    check("relock_gap_ok", (n >= 80 && n <= 96), 1'b1);
    check("relock_locked", if3.locked, 1'b1);
    check("relock_div", if3.div, 24'h000A00);

    // Asynchronous reset in the middle of a window
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_div", if3.div, 24'h0);
    check("arst_locked", if3.locked, 1'b0);
    check("arst_valid", if3.div_valid, 1'b0);
    check("arst_timeout", if3.timeout, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_valid(1'b0, 300, ok, n);
    check("post_rst_seen", ok, 1'b1);
    check("post_rst_gap_ok", (n >= 80 && n <= 96), 1'b1);
    check("post_rst_div", if3.div, 24'h000A00);
    check("post_rst_locked", if3.locked, 1'b1);

    // AVG_LOG2=0: lock at period 10, then leave the pin low until overflow
    pa0 = 10; pb0 = 10;
    if0.enable = 1'b1;
    run0 = 1'b1;
    wait_valid(1'b1, 200, ok, n);
    run0 = 1'b0;
    check("avg0_seen", ok, 1'b1);
    check("avg0_div", if0.div, 24'h000A00);
    check("avg0_locked", if0.locked, 1'b1);
    n = 0;
    saw_valid = 1'b0;
    while (!if0.timeout && n < 70000) begin
      @(negedge clk);
      n++;
      if (if0.div_valid) saw_valid = 1'b1;
    end
    check("to_seen", if0.timeout, 1'b1);
    check("to_cycles_ok", (n >= 65533 && n <= 65537), 1'b1);
    check("to_locked", if0.locked, 1'b0);
    check("to_div_held", if0.div, 24'h000A00);
    check("to_no_valid", saw_valid, 1'b0);
    check("to_fsm_arm", u_dut0.state, ARM);
    repeat (5) @(negedge clk);
    check("to_sticky", if0.timeout, 1'b1);

    // Period step 10 -> 12 -> 12 (deviation flag only with the tolerance build)
    if0.enable = 1'b0;
    repeat (2) @(negedge clk);
    check("to_cleared", if0.timeout, 1'b0);
    pa0 = 10; pb0 = 12;
    if0.enable = 1'b1;
    run0 = 1'b1;
    wait_valid(1'b1, 200, ok, n);
    check("tol1_seen", ok, 1'b1);
    check("tol1_div", if0.div, 24'h000A00);
    check("tol1_glitch", if0.glitch, 1'b0);
    wait_valid(1'b1, 40, ok, n);
    check("tol2_seen", ok, 1'b1);
    check("tol2_gap", n, 12);
    check("tol2_div", if0.div, 24'h000C00);
    check("tol2_glitch", if0.glitch, TOL);
    @(negedge clk);
    check("tol2_glitch_pulse", if0.glitch, 1'b0);
    wait_valid(1'b1, 40, ok, n);
    check("tol3_seen", ok, 1'b1);
    check("tol3_div", if0.div, 24'h000C00);
    check("tol3_glitch", if0.glitch, 1'b0);
    check("tol3_locked", if0.locked, 1'b1);
    run0 = 1'b0;
    run3 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
